// File: rtl/rr_sel_arbiter_pkg.sv
// Purpose: shared state encodings, sizes and the rotating priority pick for rr_sel_arbiter.
// Latency: n/a (types, constants and a combinational helper function only).
// Backpressure: n/a.
package rr_sel_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Returns {found, index} of the first set request, scanning ptr, ptr+1, ... with wrap.
    // The scan runs from farthest to nearest so the last hit written is the nearest one.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_dec3to8.sv
// Purpose: 3-to-8 active-low one-hot decoder with active-low enable.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module sel_dec3to8 (
    input  logic [2:0] idx,
    input  logic       en_n,
    output logic [7:0] sel_n
);

    // Drive exactly one line low when enabled, all lines high otherwise.
    always_comb begin
        sel_n = 8'hFF;
        if (!en_n) begin
            sel_n = ~(8'b0000_0001 << idx);
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Purpose: round-robin owner of one active-low 3-to-8 select, with one dead cycle between owners.
// Latency: request sampled at an edge is granted (gnt_valid/sel_n) from that edge on.
// Backpressure: owner holds until its req drops, done pulses, or MAX_HOLD preempts it for waiters.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] sel_n
);

    // Compared only when MAX_HOLD != 0, so the wrapped value for MAX_HOLD == 0 is never used.
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_SAT  = {CW{1'b1}};

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     hold_q, hold_d;

    logic [IDX_W:0]    pick;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  owner_oh;
    logic              others_wait;
    logic              preempt;
    logic              release_now;
    logic              dec_en_n;

    assign pick     = rr_pick(req, ptr_q);
    assign win_vld  = pick[IDX_W];
    assign win_idx  = pick[IDX_W-1:0];

    // Preemption needs someone else waiting, so a sole requester keeps the resource indefinitely.
    assign owner_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
    assign others_wait = |(req & ~owner_oh);
    assign preempt     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_wait;
    assign release_now = !req[idx_q] || done || preempt;

    // Next-state: arbitrate in IDLE/GAP, count and test release conditions in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_vld) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d = ST_GAP;
                    ptr_d   = idx_q + 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d  = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, owner index and hold counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_valid = (state_q == ST_GRANT);
    assign gnt_idx   = idx_q;
    assign dec_en_n  = ~gnt_valid;

    // Select decode comes only from registered state, so req/done never reach sel_n combinationally.
    sel_dec3to8 u_sel_dec (
        .idx   (idx_q),
        .en_n  (dec_en_n),
        .sel_n (sel_n)
    );

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Purpose: self-checking bench for rr_sel_arbiter against an owner/pointer reference model.
// Latency: model advances on each rising edge; outputs are sampled on the falling edge.
// Backpressure: n/a.
module tb_rr_sel_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CW       = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] sel_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the resource (-1 = nobody), where the next scan starts,
    // how many grant cycles the owner has had, and the last granted index.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cyc   = 0;
    int m_last  = 0;

    rr_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .sel_n     (sel_n)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [7:0] r, input logic d, input logic rs);
        logic others;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cyc   = 0;
            m_last  = 0;
        end else if (m_owner >= 0) begin
            others = (r & ~(8'd1 << m_owner)) != 8'd0;
            if (!r[m_owner] || d || (MAX_HOLD != 0 && m_cyc == MAX_HOLD && others)) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_cyc++;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_last  = m_owner;
                    m_cyc   = 1;
                end
            end
        end
    endtask

    function automatic logic [7:0] m_sel();
        logic [7:0] one;
        one = 8'd1;
        return (m_owner >= 0) ? ~(one << m_owner) : 8'hFF;
    endfunction

    // Apply inputs, let one rising edge happen, advance the model, then settle at the falling edge.
    task automatic step(input logic [7:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 1'b0, 1'b1);
            n_cmp++;
            if (gnt_valid !== 1'b0 || sel_n !== 8'hFF || gnt_idx !== 3'd0) begin
                n_bad++;
                $display("FAIL reset: valid=%b idx=%0d sel_n=%h, want 0/0/ff", gnt_valid, gnt_idx, sel_n);
            end
        end
    endtask

    task automatic test_sole_requester();
        for (int i = 0; i < 11; i++) begin
            step(8'h20, 1'b0, 1'b0);
            n_cmp++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5 || sel_n !== 8'hDF) begin
                n_bad++;
                $display("FAIL sole_req cyc%0d: valid=%b idx=%0d sel_n=%h, want 1/5/df", i, gnt_valid, gnt_idx, sel_n);
            end
        end
    endtask

    task automatic test_drop();
        step(8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b0 || sel_n !== 8'hFF || gnt_idx !== 3'd5) begin
            n_bad++;
            $display("FAIL drop_gap: valid=%b idx=%0d sel_n=%h, want 0/5/ff", gnt_valid, gnt_idx, sel_n);
        end
        step(8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b0 || sel_n !== 8'hFF) begin
            n_bad++;
            $display("FAIL drop_idle: valid=%b sel_n=%h, want 0/ff", gnt_valid, sel_n);
        end
        // Pointer now sits at 6, so 6 beats 0.
        step(8'h41, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6 || sel_n !== 8'hBF) begin
            n_bad++;
            $display("FAIL drop_ptr: valid=%b idx=%0d sel_n=%h, want 1/6/bf", gnt_valid, gnt_idx, sel_n);
        end
    endtask

    task automatic test_round_robin();
        step(8'hFF, 1'b0, 1'b1);
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step(8'hFF, 1'b0, 1'b0);
                n_cmp++;
                if (gnt_valid !== 1'b1 || gnt_idx !== 3'(g % 8) || $countones(~sel_n) != 1) begin
                    n_bad++;
                    $display("FAIL rr grant%0d cyc%0d: valid=%b idx=%0d sel_n=%h, want 1/%0d", g, c, gnt_valid, gnt_idx, sel_n, g % 8);
                end
            end
            if (g < 8) begin
                step(8'hFF, 1'b0, 1'b0);
                n_cmp++;
                if (gnt_valid !== 1'b0 || sel_n !== 8'hFF) begin
                    n_bad++;
                    $display("FAIL rr gap%0d: valid=%b sel_n=%h, want 0/ff", g, gnt_valid, sel_n);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] want [0:10];
        logic       wv   [0:10];
        want = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
        wv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        step(8'hFF, 1'b0, 1'b1);
        step(8'h80, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7) begin
            n_bad++;
            $display("FAIL wrap_first: valid=%b idx=%0d, want 1/7", gnt_valid, gnt_idx);
        end
        for (int i = 1; i < 11; i++) begin
            step(8'h81, 1'b0, 1'b0);
            n_cmp++;
            if (gnt_valid !== wv[i] || gnt_idx !== want[i]) begin
                n_bad++;
                $display("FAIL wrap cyc%0d: valid=%b idx=%0d, want %b/%0d", i, gnt_valid, gnt_idx, wv[i], want[i]);
            end
        end
    endtask

    task automatic test_done();
        step(8'hFF, 1'b0, 1'b1);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b0 || sel_n !== 8'hFF || gnt_idx !== 3'd2) begin
            n_bad++;
            $display("FAIL done_gap: valid=%b idx=%0d sel_n=%h, want 0/2/ff", gnt_valid, gnt_idx, sel_n);
        end
        step(8'h04, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || sel_n !== 8'hFB) begin
            n_bad++;
            $display("FAIL done_regrant: valid=%b idx=%0d sel_n=%h, want 1/2/fb", gnt_valid, gnt_idx, sel_n);
        end
        // done together with a new request: release first, then the newcomer wins in the gap.
        step(8'h0C, 1'b1, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b0 || sel_n !== 8'hFF) begin
            n_bad++;
            $display("FAIL done_newreq_gap: valid=%b sel_n=%h, want 0/ff", gnt_valid, sel_n);
        end
        step(8'h0C, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
            n_bad++;
            $display("FAIL done_newreq_grant: valid=%b idx=%0d, want 1/3", gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_reset_mid();
        step(8'hFF, 1'b0, 1'b1);
        step(8'h10, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b1);
        n_cmp++;
        if (gnt_valid !== 1'b0 || sel_n !== 8'hFF || gnt_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid: valid=%b idx=%0d sel_n=%h, want 0/0/ff", gnt_valid, gnt_idx, sel_n);
        end
        step(8'hFF, 1'b0, 1'b0);
        n_cmp++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid_scan: valid=%b idx=%0d, want 1/0", gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       d;
        logic       rs;
        r = 8'h00;
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom) & 8'($urandom);
            end
            d  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(r, d, rs);
            n_cmp++;
            if (gnt_valid !== (m_owner >= 0) || gnt_idx !== 3'(m_last) || sel_n !== m_sel()
                || $countones(~sel_n) > 1) begin
                n_bad++;
                $display("FAIL random cyc%0d: valid=%b idx=%0d sel_n=%h, want %b/%0d/%h", i, gnt_valid, gnt_idx, sel_n,
                         (m_owner >= 0), m_last, m_sel());
            end
        end
    endtask

    initial begin
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        test_reset();
        test_sole_requester();
        test_drop();
        test_round_robin();
        test_wrap();
        test_done();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
